out_channel_checker: RTL



---
 rtl/out_channel_pkg.sv | 17 +
 rtl/oc_fifo.sv | 55 +++++
 rtl/out_channel_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/out_channel_pkg.sv
// Shared types and default sizes for the out-channel checker slice.
package out_channel_pkg;

  localparam int OC_MEM_W      = 12;
  localparam int OC_NOUT       = 100;
  localparam int OC_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    OC_LOAD,
    OC_RUN,
    OC_DRAIN,
    OC_DONE
  } oc_state_t;

  typedef logic [OC_MEM_W-1:0] word_t;

endpackage

// File: rtl/oc_fifo.sv
// Small synchronous FIFO that buffers out-channel words ahead of the comparator.
// Push on full and pop on empty are ignored. Pointers wrap modulo DEPTH.
// The count is one bit wider than the pointers, so it can tell full from empty.
module oc_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array: written on accepted push, contents not reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; a simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// Self-checking sink for the program core's out channel. It buffers emitted words
// and compares them in order against a preloaded expected table. It reports
// finished/success once the program halts and every buffered word is checked.
//
// Handshake: a word transfers on a clock edge where out_valid && out_ready.
// out_ready comes only from registered state (FSM state and FIFO count).
// It never depends on out_valid and never passes through on a simultaneous pop.
module out_channel_checker
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = OC_MEM_W,
  parameter int NOut               = OC_NOUT,
  parameter int FifoDepth          = OC_FIFO_DEPTH,
  localparam int AW                = $clog2(NOut),
  localparam int CW                = $clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          program_done,
  input  logic                          exp_we,
  input  logic [AW-1:0]                 exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic [CW-1:0]                 exp_count,
  output logic [CW-1:0]                 checked,
  output logic [CW-1:0]                 mismatch_index,
  output logic                          finished,
  output logic                          success,
  // Holds the comparator off (no pops) so the bench can fill the FIFO.
  input  logic                          test_pop_hold,
  output oc_state_t                     dbg_state
);

  localparam logic [CW-1:0] NOUT_C = CW'(NOut);

  oc_state_t                     r_state;
  oc_state_t                     w_next;
  logic                          r_loaded;
  logic [MemoryElementWidth-1:0] r_table [NOut];
  logic [CW-1:0]                 r_checked;
  logic [CW-1:0]                 r_mismatch;

  logic                          w_full;
  logic                          w_empty;
  logic [MemoryElementWidth-1:0] w_head;
  logic [MemoryElementWidth-1:0] w_exp_word;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_active;
  logic                          w_extra;
  logic                          w_bad;

  assign w_push     = out_valid && out_ready;
  assign w_active   = (r_state == OC_RUN) || (r_state == OC_DRAIN);
  assign w_pop      = w_active && !w_empty && !test_pop_hold;
  // Asynchronous table read. It is only meaningful when checked < exp_count <= NOut.
  assign w_exp_word = r_table[r_checked[AW-1:0]];
  assign w_extra    = (r_checked >= exp_count);
  assign w_bad      = w_extra || (w_head != w_exp_word);

  assign checked        = r_checked;
  assign mismatch_index = r_mismatch;
  assign dbg_state      = r_state;

  oc_fifo #(
    .W     (MemoryElementWidth),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_din   (out_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= OC_LOAD;
    else       r_state <= w_next;
  end

  // Next-state and state-derived outputs.
  always_comb begin
    w_next    = r_state;
    out_ready = 1'b0;
    finished  = 1'b0;
    success   = 1'b0;
    case (r_state)
      OC_LOAD: begin
        if (exp_count == '0)         w_next = OC_RUN;
        else if (r_loaded && !exp_we) w_next = OC_RUN;
      end
      OC_RUN: begin
        out_ready = !w_full;
        if (program_done) w_next = OC_DRAIN;
      end
      OC_DRAIN: begin
        if (w_empty) w_next = OC_DONE;
      end
      OC_DONE: begin
        finished = 1'b1;
        success  = (r_mismatch == NOUT_C) && (r_checked == exp_count);
      end
      default: w_next = OC_LOAD;
    endcase
  end

  // Expected-table writes, accepted only while loading and only for in-range addresses.
  always_ff @(posedge clock) begin
    if ((r_state == OC_LOAD) && exp_we && (int'(exp_addr) < NOut))
      r_table[exp_addr] <= exp_data;
  end

  // Tracks that at least one table write happened since reset.
  always_ff @(posedge clock) begin
    if (reset)                               r_loaded <= 1'b0;
    else if ((r_state == OC_LOAD) && exp_we) r_loaded <= 1'b1;
  end

  // Comparator: each pop checks one word and records the first failing index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_checked  <= '0;
      r_mismatch <= NOUT_C;
    end else if (w_pop) begin
      if (w_bad && (r_mismatch == NOUT_C)) r_mismatch <= r_checked;
      if (r_checked != NOUT_C)             r_checked  <= r_checked + 1'b1;
    end
  end

endmodule
